// File: rtl/bnn_result_tx.sv
// Readout stage for the BNN: captures the class-score vector, finds the argmax
// sequentially and streams scores plus the winning class as bytes over valid/ready.
module bnn_result_tx #(
  parameter int unsigned N_CLASSES   = 10,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned SEND_SCORES = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [N_CLASSES*SCORE_W-1:0]   scores_i,
  output logic                           busy_o,
  output logic [7:0]                     tx_data_o,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic [IDX_W-1:0]               class_o,
  output logic                           class_valid_o,
  output logic                           done_o
);

  localparam int unsigned CNT_W = $clog2(N_CLASSES + 1);
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(N_CLASSES);
  localparam logic [CNT_W-1:0] LAST_BYTE = (SEND_SCORES != 0) ? CNT_W'(N_CLASSES) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLASSES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]                   state;
  logic [N_CLASSES*SCORE_W-1:0] scores_q;
  logic [SCORE_W-1:0]           best_val;
  logic [SCORE_W-1:0]           cur_score;
  logic [SCORE_W-1:0]           tx_score;
  logic [IDX_W-1:0]             best_idx;
  logic [IDX_W-1:0]             idx;
  logic [CNT_W-1:0]             byte_cnt;
  logic                         better;

  always_comb begin
    cur_score = scores_q[idx*SCORE_W +: SCORE_W];
    better    = cur_score > best_val;
    tx_score  = '0;
    if (byte_cnt < N_CNT) tx_score = scores_q[byte_cnt*SCORE_W +: SCORE_W];
  end

  assign busy_o     = (state != S_IDLE);
  assign tx_valid_o = (state == S_SEND);

  // Score bytes first (when enabled), class byte last; bus idles at zero.
  always_comb begin
    tx_data_o = '0;
    if (tx_valid_o) begin
      if (SEND_SCORES != 0 && byte_cnt < N_CNT) tx_data_o = 8'(tx_score);
      else                                      tx_data_o = 8'(class_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      scores_q      <= '0;
      best_val      <= '0;
      best_idx      <= '0;
      idx           <= '0;
      byte_cnt      <= '0;
      class_o       <= '0;
      class_valid_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            scores_q      <= scores_i;
            best_val      <= '0;
            best_idx      <= '0;
            idx           <= '0;
            class_valid_o <= 1'b0;
            state         <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (better) begin
            best_val <= cur_score;
            best_idx <= idx;
          end
          // Final compare result is folded straight into class_o.
          if (idx == LAST_IDX) begin
            class_o       <= better ? idx : best_idx;
            class_valid_o <= 1'b1;
            byte_cnt      <= '0;
            state         <= S_SEND;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_SEND: begin
          if (tx_ready_i) begin
            if (byte_cnt == LAST_BYTE) begin
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
